// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer reusing a single 1-bit full adder.

// 1-bit full-adder cell (combinational).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum and carry of three input bits.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// Feeds two operands LSB-first through one full adder, one bit per clock.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MSB  = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             c_msb_in;
  logic [CNT_W-1:0] cnt;

  logic load_c;
  logic step_c;
  logic last_c;
  logic fa_sum_c;
  logic fa_cout_c;

  // The single shared full adder sees the current LSBs and the carry flop.
  full_adder u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .sum  (fa_sum_c),
    .cout (fa_cout_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    step_c    = 1'b0;
    last_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load_c    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        step_c = 1'b1;
        if (cnt == CNT_LAST) begin
          last_c    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Status outputs registered from the next state so they track the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      done <= (state_nxt == ST_DONE);
    end
  end

  // Operand shift registers, carry flop and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      res      <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      cnt      <= '0;
    end else if (load_c) begin
      sa    <= a;
      sb    <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (step_c) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      res   <= {fa_sum_c, res[WIDTH-1:1]};
      carry <= fa_cout_c;
      cnt   <= cnt + CNT_W'(1);
      if (cnt == CNT_MSB) begin
        c_msb_in <= fa_cout_c;
      end
    end
  end

  // Result registers only update on the final bit, so RUN never shows partials.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (last_c) begin
      sum  <= {fa_sum_c, res[WIDTH-1:1]};
      cout <= fa_cout_c;
      ovf  <= c_msb_in ^ fa_cout_c;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8).
module tb_serial_adder_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } exp_t;

  exp_t exp_q[$];

  int nvec = 0;
  int nerr = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare every DONE pulse against the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sum",  32'(sum),  32'(e.s));
          chk("cout", 32'(cout), 32'(e.c));
          chk("ovf",  32'(ovf),  32'(e.o));
        end
      end
    end
  end

  // Drive one request at a falling edge, hold it across the accepting edge.
  task automatic issue(input logic s, input logic c, input logic [7:0] aa,
                       input logic [7:0] bb, input exp_t e);
    @(negedge clk);
    start = 1'b1; sub = s; cin = c; a = aa; b = bb;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
  endtask

  // Bounded wait for DONE, then one more cycle back to IDLE.
  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits[$];
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf",  32'(ovf),  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0x5A+0x3C with cycle-exact BUSY/DONE timing.
    issue(1'b0, 1'b0, 8'h5A, 8'h3C, '{s: 8'h96, c: 1'b0, o: 1'b1});
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      chk($sformatf("busy_e%0d", i), 32'(busy), (i <= 8) ? 32'd1 : 32'd0);
      chk($sformatf("done_e%0d", i), 32'(done), (i == 8) ? 32'd1 : 32'd0);
    end

    issue(1'b0, 1'b0, 8'hFF, 8'h01, '{s: 8'h00, c: 1'b1, o: 1'b0});
    wait_done();
    issue(1'b0, 1'b1, 8'h7F, 8'h00, '{s: 8'h80, c: 1'b0, o: 1'b1});
    wait_done();
    issue(1'b1, 1'b0, 8'h10, 8'h20, '{s: 8'hF0, c: 1'b0, o: 1'b0});
    wait_done();
    issue(1'b1, 1'b0, 8'h80, 8'h01, '{s: 8'h7F, c: 1'b1, o: 1'b1});
    wait_done();

    // New request during RUN is ignored; old result held until completion.
    issue(1'b0, 1'b0, 8'h01, 8'h01, '{s: 8'h02, c: 1'b0, o: 1'b0});
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF; sub = 1'b1;
    @(negedge clk);
    sub = 1'b0;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    chk("hold_sum",  32'(sum),  32'h7F);
    chk("hold_cout", 32'(cout), 32'd1);
    chk("hold_busy", 32'(busy), 32'd1);
    wait_done();
    repeat (12) @(negedge clk);
    chk("idle_after_ignore", 32'(busy), 32'd0);

    // START held high: one result every WIDTH+2 cycles.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; cin = 1'b0; a = 8'h03; b = 8'h04;
    repeat (3) exp_q.push_back('{s: 8'h07, c: 1'b0, o: 1'b0});
    @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) hits.push_back(i);
    end
    start = 1'b0; a = '0; b = '0;
    chk("stream_count", 32'(hits.size()), 32'd3);
    if (hits.size() == 3) begin
      chk("stream_first", 32'(hits[0]), 32'd8);
      chk("stream_gap1", 32'(hits[1] - hits[0]), 32'd10);
      chk("stream_gap2", 32'(hits[2] - hits[1]), 32'd10);
    end
    repeat (12) @(negedge clk);
    chk("stream_stop", 32'(busy), 32'd0);

    // Asynchronous reset mid-RUN, between clock edges.
    issue(1'b0, 1'b0, 8'h5A, 8'h3C, '{s: 8'h96, c: 1'b0, o: 1'b1});
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_sum",  32'(sum),  32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    chk("arst_ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    chk("post_rst_sum",  32'(sum),  32'd0);
    issue(1'b0, 1'b0, 8'h5A, 8'h3C, '{s: 8'h96, c: 1'b0, o: 1'b1});
    wait_done();

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview: Bit-serial add/subtract sequencer built around one instance of the existing 1-bit full-adder cell (ports A, B, Cin, SUM, Cout). The block accepts two WIDTH-bit operands on a START strobe and feeds them LSB-first through the single full adder, one bit per clock, holding the carry in a flip-flop between bits. It then presents the registered sum, carry-out and signed overflow with a one-cycle DONE pulse. It is the standard way to reuse one full adder for multi-bit arithmetic in gate-level designs.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
CLK  input  1  clock; all state changes on rising edge.
RST_N  input  1  asynchronous reset, active low.
START  input  1  request; sampled only in IDLE.
SUB  input  1  0 = A+B+CIN; 1 = A-B (two's complement), CIN ignored.
CIN  input  1  carry-in for add mode.
A  input  WIDTH  operand A, captured on the accepting edge.
B  input  WIDTH  operand B, captured on the accepting edge.
BUSY  output  1  high whenever state != IDLE.
DONE  output  1  one-cycle pulse, high in DONE state.
SUM  output  WIDTH  result register.
COUT  output  1  final carry-out; in SUB mode 1 = no borrow.
OVF  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: RST_N low forces the following immediately, regardless of CLK: state IDLE; BUSY=0, DONE=0, SUM=0, COUT=0, OVF=0; shift registers, carry flip-flop and bit counter cleared.
- Reset mid-operation aborts the operation. No partial result appears on SUM.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with START=1, latch A into shift register SA.
  - Latch B into shift register SB, or ~B when SUB=1.
  - Load the carry flip-flop with CIN (SUB=0) or 1 (SUB=1).
  - Clear the bit counter (width clog2(WIDTH)) and go to RUN.
  - START=0: stay in IDLE.
- RUN:
  - The full adder inputs are SA[0], SB[0] and the carry flip-flop.
  - Each edge: shift the adder SUM bit into the MSB of an internal result shift register (right shift); shift SA and SB right; load the carry flip-flop with Cout; increment the counter.
  - On the edge that processes bit WIDTH-2, capture the adder Cout into a c_msb_in flop (carry into MSB).
  - On the edge that processes bit WIDTH-1 (counter == WIDTH-1), go to DONE.
  - On that same edge, load the output registers: SUM = completed shift value; COUT = adder Cout; OVF = c_msb_in XOR adder Cout.
- DONE: DONE=1 for exactly one cycle, then IDLE on the next edge.
- Latency: START accepted at edge E0; DONE high after edge E0+WIDTH; IDLE again after edge E0+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles back-to-back.
- START, A, B, SUB and CIN are ignored while BUSY=1, including the DONE cycle. Operand changes after acceptance have no effect.
- SUM, COUT and OVF hold their last completed value until the next completion or reset. They do not change during RUN.
- Arithmetic: SUM = (A + B' + c0) mod 2^WIDTH, where B' = B (add) or ~B (sub) and c0 = CIN (add) or 1 (sub).

Test Plan:
- WIDTH=8, SUB=0, CIN=0, A=0x5A, B=0x3C, START pulse at E0 -> DONE high only after E8; SUM=0x96, COUT=0, OVF=1; BUSY high after E0 through E8, low after E9.
- SUB=0, CIN=0, A=0xFF, B=0x01 -> SUM=0x00, COUT=1, OVF=0. Then SUB=0, CIN=1, A=0x7F, B=0x00 -> SUM=0x80, COUT=0, OVF=1.
- SUB=1, A=0x10, B=0x20 -> SUM=0xF0, COUT=0, OVF=0. Then SUB=1, A=0x80, B=0x01 -> SUM=0x7F, COUT=1, OVF=1.
- During RUN of 0x01+0x01, pulse START with A=0xFF, B=0xFF and toggle SUB -> new request ignored; SUM=0x02, COUT=0. Previous SUM is held unchanged until the DONE edge.
- START held high continuously with 0x03+0x04 -> results every 10 cycles (WIDTH+2); DONE pulses exactly one cycle wide. START during the DONE cycle is not accepted.
- Assert RST_N low at an arbitrary RUN cycle between clock edges -> BUSY, DONE, SUM, COUT and OVF go to 0 immediately. After release, with START low, the block stays IDLE. A fresh 0x5A+0x3C then completes correctly.
